// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: fetch port, load/store port, shared memory port and busy.
// The master modport is the arbiter's view and the slave modport is the requester/memory view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic          m_en;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_be, m_addr, m_wdata, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_en, m_we, m_be, m_addr, m_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (I) and load/store (D); ties alternate, first tie goes to I.
// Request seen in IDLE cycle N: ACCESS N+1..N+LAT, ack pulse N+LAT+1; requests ignored outside IDLE.
module mem_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 2
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic          r_last_d;
    logic          r_gnt_d;
    logic          r_we;
    logic [3:0]    r_be;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          w_grant;
    logic          w_pick_d;
    logic          w_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pick_d    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    w_grant     = 1'b1;
                    // On a tie, D wins only if I was granted last.
                    w_pick_d    = bus.d_req && (!bus.i_req || !r_last_d);
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_done      = 1'b1;
                    w_state_nxt = ACK;
                end
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_last_d  <= 1'b1;
            r_gnt_d   <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= 4'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_gnt_d  <= w_pick_d;
                r_last_d <= w_pick_d;
                r_cnt    <= LAT_M1;
                if (w_pick_d) begin
                    r_we    <= bus.d_we;
                    r_be    <= bus.d_be;
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_we    <= 1'b0;
                    r_be    <= 4'b1111;
                    r_addr  <= bus.i_addr;
                    r_wdata <= '0;
                end
            end else if (r_state == ACCESS && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_done) begin
                if (!r_gnt_d) begin
                    r_i_rdata <= bus.m_rdata;
                end else if (!r_we) begin
                    r_d_rdata <= bus.m_rdata;
                end
            end
        end
    end

    assign bus.m_en    = (r_state == ACCESS);
    assign bus.m_we    = r_we && (r_state == ACCESS);
    assign bus.m_be    = r_be;
    assign bus.m_addr  = r_addr;
    assign bus.m_wdata = r_wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_rdata = r_d_rdata;
    assign bus.i_ack   = (r_state == ACK) && !r_gnt_d;
    assign bus.d_ack   = (r_state == ACK) && r_gnt_d;
    assign bus.busy    = (r_state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: predictor queues expected accesses, monitor checks on DUT activity.
module tb_mem_arbiter;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();
    mem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mem_arbiter #(.AW(32), .DW(32), .LAT(1))   dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // Memory returns an address hash mixed with the cycle number, so capture timing is visible.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    assign bus.m_rdata  = mem_f(bus.m_addr) ^ 32'(cyc);
    assign bus1.m_rdata = mem_f(bus1.m_addr) ^ 32'(cyc);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          due;
    } txn_t;

    txn_t exp_q[$];

    // Predictor: one access occupies the port for LAT+2 cycles from the sampling IDLE cycle.
    int   rem = 0;
    bit   last_d = 1'b1;
    txn_t p_t;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            rem    = 0;
            last_d = 1'b1;
        end else begin
            if (rem > 0) rem = rem - 1;
            if (rem == 0 && (bus.i_req || bus.d_req)) begin
                if (bus.i_req && bus.d_req) p_t.is_d = !last_d;
                else                        p_t.is_d = bus.d_req;
                if (p_t.is_d) begin
                    p_t.we = bus.d_we; p_t.be = bus.d_be; p_t.addr = bus.d_addr; p_t.wdata = bus.d_wdata;
                end else begin
                    p_t.we = 1'b0; p_t.be = 4'hF; p_t.addr = bus.i_addr; p_t.wdata = 32'd0;
                end
                p_t.due   = cyc + LAT + 1;
                p_t.rdata = mem_f(p_t.addr) ^ 32'(cyc + LAT);
                exp_q.push_back(p_t);
                last_d = p_t.is_d;
                rem    = LAT + 2;
            end
        end
    end

    // Monitor
    logic [31:0] exp_i = 32'd0;
    logic [31:0] exp_d = 32'd0;
    txn_t        m_t;
    bit          m_have;
    bit          m_acc;
    always @(negedge clk) begin
        if (rst) begin
            exp_i = 32'd0;
            exp_d = 32'd0;
            chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
            chk("rst_addr_wdata", {bus.m_addr, bus.m_wdata}, 64'd0);
            chk("rst_ctrl", 64'({bus.m_be, bus.i_ack, bus.d_ack, bus.m_en, bus.m_we, bus.busy}), 64'd0);
        end else begin
            m_have = exp_q.size() > 0;
            if (m_have) m_t = exp_q[0];
            m_acc = m_have && (cyc >= m_t.due - LAT) && (cyc < m_t.due);
            chk("m_en", 64'(bus.m_en), 64'(m_acc));
            chk("m_we", 64'(bus.m_we), 64'(m_acc && m_t.we));
            chk("busy", 64'(bus.busy), 64'(m_have && cyc >= m_t.due - LAT));
            if (m_acc) begin
                chk("m_addr", 64'(bus.m_addr), 64'(m_t.addr));
                chk("m_be_wdata", {28'd0, bus.m_be, bus.m_wdata}, {28'd0, m_t.be, m_t.wdata});
            end
            chk("ack_exclusive", 64'(bus.i_ack && bus.d_ack), 64'd0);
            if (bus.i_ack || bus.d_ack) begin
                if (!m_have) begin
                    chk("ack_spurious", 64'({bus.i_ack, bus.d_ack}), 64'd0);
                end else begin
                    void'(exp_q.pop_front());
                    chk("ack_port", 64'(bus.d_ack), 64'(m_t.is_d));
                    chk("ack_cycle", 64'(cyc), 64'(m_t.due));
                    if (!m_t.is_d)     exp_i = m_t.rdata;
                    else if (!m_t.we)  exp_d = m_t.rdata;
                end
            end else if (m_have && cyc >= m_t.due) begin
                chk("ack_missing", 64'(bus.i_ack || bus.d_ack), 64'd1);
                void'(exp_q.pop_front());
            end
            chk("i_rdata", 64'(bus.i_rdata), 64'(exp_i));
            chk("d_rdata", 64'(bus.d_rdata), 64'(exp_d));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit is_d, input int bound);
        bit got;
        got = 1'b0;
        for (int k = 0; k < bound && !got; k++) begin
            @(negedge clk);
            if (is_d ? bus.d_ack : bus.i_ack) got = 1'b1;
        end
        chk(is_d ? "d_ack_wait" : "i_ack_wait", 64'(got), 64'd1);
    endtask

    task automatic d_access(input bit we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wdata);
        tick();
        bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
        wait_ack(1'b1, 20);
        tick();
        bus.d_req = 1'b0;
    endtask

    task automatic i_access(input logic [31:0] addr);
        tick();
        bus.i_addr = addr; bus.i_req = 1'b1;
        wait_ack(1'b0, 20);
        tick();
        bus.i_req = 1'b0;
    endtask

    task automatic req_proc(input bit is_d, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            if (is_d) begin
                bus.d_we = 1'($urandom_range(0, 1)); bus.d_be = 4'($urandom);
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_req = 1'b1;
            end else begin
                bus.i_addr = $urandom; bus.i_req = 1'b1;
            end
            wait_ack(is_d, 40);
            tick();
            if (is_d) bus.d_req = 1'b0;
            else      bus.i_req = 1'b0;
        end
    endtask

    int       nack;
    bit [2:0] order;
    int       c0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0;
        bus1.i_req = 0; bus1.i_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_be = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Tie right after reset: I, then D, then I again.
        tick();
        bus.i_addr = 32'h300; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h400;
        bus.d_wdata = 32'd0; bus.i_req = 1'b1; bus.d_req = 1'b1;
        nack = 0; order = 3'b000;
        for (int k = 0; k < 40 && nack < 3; k++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) begin
                order[nack] = bus.d_ack;
                nack++;
            end
        end
        tick();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        chk("tie_count", 64'(nack), 64'd3);
        chk("tie_order", 64'(order), 64'(3'b010));

        i_access(32'h100);
        d_access(1'b1, 4'b0011, 32'h200, 32'hDEADBEEF);
        d_access(1'b0, 4'b1111, 32'h204, 32'd0);
        d_access(1'b1, 4'b0000, 32'h207, 32'h1234_5678);
        i_access(32'h0000_0003);

        // Request dropped mid-access: exactly one ack, no re-grant.
        tick();
        bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h500; bus.d_req = 1'b1;
        tick();
        tick();
        bus.d_req = 1'b0;
        nack = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.d_ack) nack++;
        end
        chk("drop_ack_count", 64'(nack), 64'd1);

        fork
            req_proc(1'b0, 25);
            req_proc(1'b1, 25);
        join
        repeat (6) tick();

        // Reset pulsed in the middle of a load.
        tick();
        bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h600; bus.d_req = 1'b1;
        tick();
        #2 rst = 1'b1;
        bus.d_req = 1'b0;
        #1;
        chk("async_rst_ctrl",
            64'({bus.m_be, bus.i_ack, bus.d_ack, bus.m_en, bus.m_we, bus.busy}), 64'd0);
        chk("async_rst_data", {bus.m_addr, bus.m_wdata}, 64'd0);
        chk("async_rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        nack = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.d_ack) nack++;
        end
        chk("rst_no_d_ack", 64'(nack), 64'd0);
        i_access(32'h700);

        // LAT=1 instance, fetch held high: m_en every 3rd cycle, ack the cycle after.
        tick();
        bus1.i_addr = 32'h800; bus1.i_req = 1'b1;
        c0 = cyc;
        repeat (12) begin
            @(negedge clk);
            chk("lat1_m_en", 64'(bus1.m_en), 64'(((cyc - c0) % 3) == 1));
            chk("lat1_i_ack", 64'(bus1.i_ack), 64'(((cyc - c0) % 3) == 2));
            if (((cyc - c0) % 3) == 2)
                chk("lat1_i_rdata", 64'(bus1.i_rdata), 64'(mem_f(32'h800) ^ 32'(cyc - 1)));
        end
        tick();
        bus1.i_req = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
